// File: rtl/dma_controller_pkg.sv
// Shared types and sizing helpers for the bus-master DMA engine.
// Widths default to the memory-port word and the length field.
package dma_controller_pkg;

  localparam int DMA_WORD_SIZE = 16;
  localparam int DMA_LEN_W     = 4;

  typedef enum logic [2:0] {
    DMA_IDLE = 3'd0,
    DMA_REQ  = 3'd1,
    DMA_XFER = 3'd2,
    DMA_GAP  = 3'd3,
    DMA_DONE = 3'd4
  } dma_state_t;

  // Counter width able to hold 0..max_val, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/dma_controller_if.sv
// CPU-side command, arbitration and device-buffer signals of the DMA engine.
// master = DMA engine, slave = CPU / device buffer side.
interface dma_controller_if #(
  parameter int WORD_SIZE = 16,
  parameter int LEN_W     = 4
);

  logic                 cmd_valid;
  logic [WORD_SIZE-1:0] cmd_addr;
  logic [LEN_W-1:0]     cmd_length;
  logic                 BG;
  logic [WORD_SIZE-1:0] dev_data;
  logic                 BR;
  logic                 Interrupt;
  logic                 busy;
  logic [LEN_W-1:0]     dev_offset;

  modport master (
    input  cmd_valid, cmd_addr, cmd_length, BG, dev_data,
    output BR, Interrupt, busy, dev_offset
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_length, BG, dev_data,
    input  BR, Interrupt, busy, dev_offset
  );

endinterface

// File: rtl/dma_controller_bus_driver.sv
// Tristate driver for the shared memory port 2 write bus.
// Latency: combinational; the bus is released the instant BG drops.
// Backpressure: none; ownership is purely (state == XFER && BG).
module dma_bus_driver
  import dma_controller_pkg::*;
#(
  parameter int WORD_SIZE = DMA_WORD_SIZE
) (
  input  dma_state_t           state,
  input  logic                 BG,
  input  logic [WORD_SIZE-1:0] wr_addr,
  input  logic [WORD_SIZE-1:0] wr_data,
  output logic                 own_bus,
  output wire                  writeM2,
  output wire  [WORD_SIZE-1:0] address2,
  inout  wire  [WORD_SIZE-1:0] data2
);

  assign own_bus  = (state == DMA_XFER) && BG;

  assign writeM2  = own_bus ? 1'b1    : 1'bz;
  assign address2 = own_bus ? wr_addr : {WORD_SIZE{1'bz}};
  assign data2    = own_bus ? wr_data : {WORD_SIZE{1'bz}};

endmodule

// File: rtl/dma_controller.sv
// Bus-master DMA: copies a block of device-buffer words into data memory over port 2.
// Latency: BR the cycle after the command; each word held WRITE_LATENCY cycles once granted.
// Backpressure: BG gates every bus cycle; a revoked grant restarts the current word.
module dma_controller
  import dma_controller_pkg::*;
#(
  parameter int WORD_SIZE     = DMA_WORD_SIZE,
  parameter int LEN_W         = DMA_LEN_W,
  parameter int BURST_LEN     = 4,
  parameter int WRITE_LATENCY = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  dma_controller_if.master     dma,
  output wire                  writeM2,
  output wire  [WORD_SIZE-1:0] address2,
  inout  wire  [WORD_SIZE-1:0] data2
);

  localparam int LAT_W   = cnt_width(WRITE_LATENCY - 1);
  localparam int BURST_W = cnt_width(BURST_LEN);

  typedef struct packed {
    logic [WORD_SIZE-1:0] addr;
    logic [LEN_W-1:0]     length;
  } cmd_t;

  dma_state_t           state_q;
  dma_state_t           state_nxt;
  cmd_t                 cmd_q;
  logic [LEN_W-1:0]     count_q;
  logic [BURST_W-1:0]   burst_q;
  logic [LAT_W-1:0]     lat_q;

  logic                 own_bus;
  logic                 last_lat;
  logic                 commit;
  logic [LEN_W-1:0]     count_inc;
  logic [BURST_W-1:0]   burst_inc;
  logic [WORD_SIZE-1:0] wr_addr;
  logic                 br;
  logic                 irq;
  logic                 busy;

  assign last_lat  = (lat_q == LAT_W'(WRITE_LATENCY - 1));
  assign commit    = own_bus && last_lat;
  assign count_inc = count_q + LEN_W'(1);
  assign burst_inc = burst_q + BURST_W'(1);
  // Wraps modulo 2^WORD_SIZE by construction.
  assign wr_addr   = cmd_q.addr + WORD_SIZE'(count_q);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= DMA_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    br        = 1'b0;
    irq       = 1'b0;
    busy      = 1'b1;
    case (state_q)
      DMA_IDLE: begin
        busy = 1'b0;
        if (dma.cmd_valid) begin
          state_nxt = (dma.cmd_length != '0) ? DMA_REQ : DMA_DONE;
        end
      end
      DMA_REQ: begin
        br = 1'b1;
        if (dma.BG) begin
          state_nxt = DMA_XFER;
        end
      end
      DMA_XFER: begin
        br = 1'b1;
        // Losing the grant abandons the in-flight word; BR stays up to win it back.
        if (!dma.BG) begin
          state_nxt = DMA_REQ;
        end else if (last_lat) begin
          if (count_inc == cmd_q.length) begin
            state_nxt = DMA_DONE;
          end else if (burst_inc == BURST_W'(BURST_LEN)) begin
            state_nxt = DMA_GAP;
          end
        end
      end
      DMA_GAP: begin
        state_nxt = DMA_REQ;
      end
      DMA_DONE: begin
        irq       = 1'b1;
        state_nxt = DMA_IDLE;
      end
      default: begin
        state_nxt = DMA_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cmd_q   <= '0;
      count_q <= '0;
      burst_q <= '0;
      lat_q   <= '0;
    end else begin
      if (state_q == DMA_IDLE && dma.cmd_valid) begin
        cmd_q.addr   <= dma.cmd_addr;
        cmd_q.length <= dma.cmd_length;
        count_q      <= '0;
        burst_q      <= '0;
      end
      if (state_q == DMA_GAP) begin
        burst_q <= '0;
      end
      if (own_bus && !last_lat) begin
        lat_q <= lat_q + LAT_W'(1);
      end else begin
        lat_q <= '0;
      end
      if (commit) begin
        count_q <= count_inc;
        burst_q <= burst_inc;
      end
    end
  end

  assign dma.BR         = br;
  assign dma.Interrupt  = irq;
  assign dma.busy       = busy;
  assign dma.dev_offset = count_q;

  dma_bus_driver #(
    .WORD_SIZE (WORD_SIZE)
  ) u_bus_driver (
    .state    (state_q),
    .BG       (dma.BG),
    .wr_addr  (wr_addr),
    .wr_data  (dma.dev_data),
    .own_bus  (own_bus),
    .writeM2  (writeM2),
    .address2 (address2),
    .data2    (data2)
  );

endmodule
